// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only I-cache with single-outstanding line refill.
module instruction_cache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  req,
  input  logic                  invalidate,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [15:0]           miss_count
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int LW = ADDR_WIDTH - 2 - OW;
  localparam int TW = LW - IW;

  typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] data [LINES][WORDS_PER_LINE];
  logic [TW-1:0]         tags [LINES];
  logic [LINES-1:0]      valid;
  logic [LW-1:0]         line;
  logic [OW-1:0]         beat;
  logic                  inv_seen;
  logic                  miss;

  logic [LW-1:0] pc_line;
  logic [IW-1:0] pc_idx, line_idx;
  logic [TW-1:0] pc_tag, line_tag;
  logic [OW-1:0] pc_off;

  assign pc_line  = pc[ADDR_WIDTH-1:2+OW];
  assign pc_off   = pc[2 +: OW];
  assign pc_idx   = pc_line[IW-1:0];
  assign pc_tag   = pc_line[LW-1:IW];
  assign line_idx = line[IW-1:0];
  assign line_tag = line[LW-1:IW];

  always_comb begin
    state_nx    = state;
    hit         = state == IDLE && req && !invalidate && valid[pc_idx] && tags[pc_idx] == pc_tag;
    instruction = hit ? data[pc_idx][pc_off] : '0;
    miss        = state == IDLE && req && !hit;
    mem_req     = state == REFILL;
    mem_addr    = mem_req ? {line, beat, 2'b00} : '0;
    busy        = state != IDLE;
    case (state)
      IDLE:    state_nx = miss ? REFILL : IDLE;
      REFILL:  state_nx = mem_valid && &beat ? FILL_DONE : REFILL;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      line       <= '0;
      beat       <= '0;
      inv_seen   <= 1'b0;
      miss_count <= '0;
    end else begin
      state <= state_nx;
      if (miss) begin
        line       <= pc_line;
        beat       <= '0;
        inv_seen   <= 1'b0;
        miss_count <= miss_count == 16'hFFFF ? miss_count : miss_count + 16'd1;
      end else if (invalidate && state != IDLE) begin
        inv_seen <= 1'b1;
      end
      if (state == REFILL && mem_valid)
        beat <= beat + 1'b1;
      // invalidate in the FILL_DONE cycle wins over validating the new line
      if (invalidate)
        valid <= '0;
      else if (state == FILL_DONE && !inv_seen)
        valid[line_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == REFILL && mem_valid) begin
      data[line_idx][beat] <= mem_rdata;
      if (&beat)
        tags[line_idx] <= line_tag;
    end
  end
endmodule
